// File: rtl/uivbuf_ctrl.sv
// Write/read frame-buffer index controller for an N-buffer VDMA ring.
// Define UIVBUF_STAT_EN to build the drop/repeat statistics counters.
module uivbuf_ctrl #(
  parameter int BUF_LENTH = 3,
  parameter int BUF_DELAY = 1
) (
  input  logic        I_clk,
  input  logic        I_rstn,
  input  logic        I_wr_fe,
  input  logic        I_rd_fs,
  input  logic        I_freeze,
  output logic [7:0]  O_wr_bufn,
  output logic [7:0]  O_rd_bufn,
  output logic        O_rd_valid,
  output logic [15:0] O_drop_cnt,
  output logic [15:0] O_rep_cnt,
  output logic        O_dbg_state
);

  generate
    if (BUF_LENTH < 2 || BUF_LENTH > 8 || BUF_DELAY < 1 || BUF_DELAY >= BUF_LENTH) begin : g_bad_param
      $error("uivbuf_ctrl: illegal BUF_LENTH/BUF_DELAY combination");
    end
  endgenerate

  localparam logic [3:0] L_LEN = 4'(BUF_LENTH);
  localparam logic [3:0] L_DLY = 4'(BUF_DELAY);

  typedef enum logic {S_FILL = 1'b0, S_RUN = 1'b1} state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_wr_bufn, r_rd_bufn, w_wr_nxt, w_rd_calc;
  logic [3:0] r_fill_cnt, w_fill_nxt, w_wr_ext, w_rd_sum;
  logic       w_rd_fire, w_valid;

  assign w_wr_ext = {1'b0, r_wr_bufn};

  always_comb begin
    w_wr_nxt    = r_wr_bufn;
    w_fill_nxt  = r_fill_cnt;
    w_state_nxt = r_state;
    w_rd_fire   = 1'b0;
    w_valid     = 1'b0;
    if (I_wr_fe) begin
      w_wr_nxt = (w_wr_ext == L_LEN - 4'd1) ? 3'd0 : r_wr_bufn + 3'd1;
      if (r_fill_cnt < L_DLY) w_fill_nxt = r_fill_cnt + 4'd1;
    end
    // Read target trails the pre-increment write index by BUF_DELAY, wrapped into the ring.
    w_rd_sum  = (w_wr_ext < L_DLY) ? (L_LEN - L_DLY + w_wr_ext) : (w_wr_ext - L_DLY);
    w_rd_calc = w_rd_sum[2:0];
    case (r_state)
      S_FILL: begin
        if (w_fill_nxt == L_DLY) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_valid   = 1'b1;
        w_rd_fire = I_rd_fs;
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      r_state    <= S_FILL;
      r_wr_bufn  <= 3'd0;
      r_rd_bufn  <= 3'd0;
      r_fill_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_bufn  <= w_wr_nxt;
      r_fill_cnt <= w_fill_nxt;
      if (w_rd_fire && !I_freeze) r_rd_bufn <= w_rd_calc;
    end
  end

  assign O_wr_bufn   = {5'd0, r_wr_bufn};
  assign O_rd_bufn   = {5'd0, r_rd_bufn};
  assign O_rd_valid  = w_valid;
  assign O_dbg_state = r_state;

`ifdef UIVBUF_STAT_EN
  logic        r_first;
  logic [15:0] r_drop_cnt, r_rep_cnt;
  logic [3:0]  w_diff_raw, w_diff;
  logic [16:0] w_drop_sum;

  always_comb begin
    w_diff_raw = {1'b0, w_rd_calc} + L_LEN - {1'b0, r_rd_bufn};
    w_diff     = (w_diff_raw >= L_LEN) ? (w_diff_raw - L_LEN) : w_diff_raw;
    w_drop_sum = {1'b0, r_drop_cnt} + {13'd0, w_diff - 4'd1};
  end

  // The first accepted read start after priming has no previous frame to compare with.
  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      r_first    <= 1'b1;
      r_drop_cnt <= 16'd0;
      r_rep_cnt  <= 16'd0;
    end else if (w_rd_fire) begin
      r_first <= 1'b0;
      if (!r_first) begin
        if (I_freeze || w_diff == 4'd0) begin
          if (r_rep_cnt != 16'hFFFF) r_rep_cnt <= r_rep_cnt + 16'd1;
        end else if (w_diff > 4'd1) begin
          r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
      end
    end
  end

  assign O_drop_cnt = r_drop_cnt;
  assign O_rep_cnt  = r_rep_cnt;
`else
  assign O_drop_cnt = 16'd0;
  assign O_rep_cnt  = 16'd0;
`endif

endmodule
